// File: rtl/phy_lane_stimgen.sv
// Lane stimulus generator: power-of-two rate strobes derived from one clock, and a
// comma preamble followed by a programmable data burst on LANES x WIDTH lanes.
module phy_lane_stimgen #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIV_LOG2 = 5,
    parameter int unsigned SYNC_LEN = 4,
    parameter logic [7:0]  COMMA    = 8'hBC,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                   i_clk32f,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [1:0]             i_mode,
    input  logic [2:0]             i_rate_sel,
    input  logic [15:0]            i_burst_len,
    input  logic [LANES-1:0]       i_lane_mask,
    output logic [DIV_LOG2:0]      o_ce,
    output logic [LANES*WIDTH-1:0] o_data_out,
    output logic [LANES-1:0]       o_valid_out,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [15:0] SYNC_LAST = 16'(SYNC_LEN - 1);
    localparam logic [2:0]  RATE_MAX  = 3'(DIV_LOG2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Taps 16,14,13,11 of the Fibonacci polynomial, shifted left with feedback into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [WIDTH-1:0] lane_word(
        input logic [1:0]  mode,
        input logic [15:0] idx,
        input int unsigned lane,
        input logic [15:0] lfsr
    );
        logic [31:0]      lin;
        logic [15:0]      rot;
        logic [WIDTH-1:0] one_hot;
        int unsigned      pos;
        lin     = (32'(idx) * LANES) + lane;
        rot     = (lfsr << lane) | (lfsr >> (32'd16 - lane));
        pos     = (32'(idx) + lane) % WIDTH;
        one_hot = {{(WIDTH-1){1'b0}}, 1'b1} << pos;
        case (mode)
            2'd0:    return lin[WIDTH-1:0];
            2'd1:    return SEED[WIDTH-1:0];
            2'd2:    return rot[WIDTH-1:0];
            2'd3:    return one_hot;
            default: return '0;
        endcase
    endfunction

    logic [DIV_LOG2-1:0]    r_div_cnt;
    state_t                 r_state;
    logic [1:0]             r_mode;
    logic [2:0]             r_rate;
    logic [15:0]            r_len;
    logic [LANES-1:0]       r_mask;
    logic [15:0]            r_cnt;
    logic [15:0]            r_lfsr;
    logic [LANES*WIDTH-1:0] r_data;
    logic [LANES-1:0]       r_valid;
    logic                   r_busy;
    logic                   r_done;

    logic [2:0]             w_rate_clamped;
    logic                   w_stb;
    logic [LANES*WIDTH-1:0] w_comma_word;
    logic [LANES*WIDTH-1:0] w_data_word;

    // Free-running divider counter that all rate strobes decode from.
    always_ff @(posedge i_clk32f) begin
        if (i_reset) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_LOG2'(1);
        end
    end

    assign o_ce[0] = 1'b1;
    for (genvar g = 1; g <= DIV_LOG2; g++) begin : g_ce
        assign o_ce[g] = &r_div_cnt[g-1:0];
    end

    assign w_rate_clamped = (i_rate_sel > RATE_MAX) ? RATE_MAX : i_rate_sel;
    assign w_stb          = o_ce[r_rate];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_comma_word[g*WIDTH +: WIDTH] = WIDTH'(COMMA);
        assign w_data_word[g*WIDTH +: WIDTH]  = lane_word(r_mode, r_cnt, 32'(g), r_lfsr);
    end

    // Burst sequencer; r_cnt counts commas in SYNC and is the word index in DATA.
    always_ff @(posedge i_clk32f) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_mode  <= 2'd0;
            r_rate  <= 3'd0;
            r_len   <= 16'd0;
            r_mask  <= '0;
            r_cnt   <= 16'd0;
            r_lfsr  <= SEED;
            r_data  <= '0;
            r_valid <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mode  <= i_mode;
                        r_rate  <= w_rate_clamped;
                        r_len   <= i_burst_len;
                        r_mask  <= i_lane_mask;
                        r_cnt   <= 16'd0;
                        r_lfsr  <= SEED;
                        r_busy  <= 1'b1;
                        r_state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (w_stb) begin
                        r_data  <= w_comma_word;
                        r_valid <= r_mask;
                        if (r_cnt == SYNC_LAST) begin
                            r_cnt   <= 16'd0;
                            r_state <= (r_len == 16'd0) ? ST_DONE : ST_DATA;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_stb) begin
                        r_data  <= w_data_word;
                        r_valid <= r_mask;
                        r_lfsr  <= lfsr_next(r_lfsr);
                        r_cnt   <= r_cnt + 16'd1;
                        if (r_cnt == (r_len - 16'd1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_stb) begin
                        r_data  <= '0;
                        r_valid <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data_out  = r_data;
    assign o_valid_out = r_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_phy_lane_stimgen.sv
// Directed and randomised bursts for phy_lane_stimgen, checked against a queue-based
// reference built from the word rules with plain arithmetic.
module tb_phy_lane_stimgen;

    localparam int SYNC_LEN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [2:0]  rate_sel;
    logic [15:0] burst_len;
    logic [3:0]  lane_mask;
    logic [5:0]  ce;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int tb_div = 0;

    logic [31:0] exp_data[$];
    logic [3:0]  exp_valid[$];
    bit          exp_done[$];
    logic [31:0] obs_data[$];
    logic [31:0] prev_data;
    logic [3:0]  prev_valid;
    logic        prev_busy;

    phy_lane_stimgen dut (
        .i_clk32f   (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_mode     (mode),
        .i_rate_sel (rate_sel),
        .i_burst_len(burst_len),
        .i_lane_mask(lane_mask),
        .o_ce       (ce),
        .o_data_out (data_out),
        .o_valid_out(valid_out),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit was_rst;
        was_rst = rst;
        @(posedge clk);
        #1;
        if (was_rst) tb_div = 0;
        else         tb_div = tb_div + 1;
    endtask

    function automatic logic [5:0] ce_model(input int d);
        logic [5:0] c;
        for (int k = 0; k <= 5; k++) c[k] = ((d % (1 << k)) == ((1 << k) - 1));
        return c;
    endfunction

    function automatic void build(input int m, input int len, input logic [3:0] mask);
        logic [15:0] s;
        logic [31:0] w;
        int          v;
        exp_data.delete(); exp_valid.delete(); exp_done.delete();
        for (int j = 0; j < SYNC_LEN; j++) begin
            exp_data.push_back(32'hBCBC_BCBC); exp_valid.push_back(mask); exp_done.push_back(1'b0);
        end
        s = 16'hACE1;
        for (int i = 0; i < len; i++) begin
            w = 32'd0;
            for (int l = 0; l < 4; l++) begin
                case (m)
                    0:       v = (i * 4 + l) % 256;
                    1:       v = 32'hE1;
                    2:       v = ((int'(s) << l) | (int'(s) >> (16 - l))) & 255;
                    default: v = 1 << ((i + l) % 8);
                endcase
                w[8*l +: 8] = v[7:0];
            end
            exp_data.push_back(w); exp_valid.push_back(mask); exp_done.push_back(1'b0);
            s = {s[14:0], ^(s & 16'hB400)};
        end
        exp_data.push_back(32'd0); exp_valid.push_back(4'd0); exp_done.push_back(1'b1);
    endfunction

    task automatic run_burst(input int m, input int rate_v, input int len_v,
                             input logic [3:0] mask_v, input bit noisy, input int abort_at);
        int r;
        int step;
        bit stb;
        r = (rate_v > 5) ? 5 : rate_v;
        build(m, len_v, mask_v);
        obs_data.delete();
        mode = 2'(m); rate_sel = 3'(rate_v); burst_len = 16'(len_v); lane_mask = mask_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        prev_busy = 1'b1;
        step = 0;
        for (int e = 0; e < exp_data.size(); e++) begin
            if (e == abort_at) begin
                rst = 1'b1; start = 1'b1;
                tick();
                start = 1'b0;
                chk("rst_data", data_out, 32'd0);
                chk("rst_valid", 32'(valid_out), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_ce", 32'(ce), 32'(ce_model(tb_div)));
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    tick();
                    chk("post_rst_done", 32'(done), 32'd0);
                    chk("post_rst_busy", 32'(busy), 32'd0);
                end
                prev_data = 32'd0; prev_valid = 4'd0; prev_busy = 1'b0;
                return;
            end
            stb = 1'b0;
            while (!stb) begin
                stb = ((tb_div % (1 << r)) == ((1 << r) - 1));
                if (noisy) begin
                    start = (step == 1);
                    mode = 2'($urandom); rate_sel = 3'($urandom);
                    burst_len = 16'($urandom); lane_mask = 4'($urandom);
                end
                tick();
                step++;
                if (!stb) begin
                    chk("hold_data", data_out, prev_data);
                    chk("hold_valid", 32'(valid_out), 32'(prev_valid));
                    chk("hold_done", 32'(done), 32'd0);
                    chk("hold_busy", 32'(busy), 32'(prev_busy));
                end
            end
            start = 1'b0;
            chk($sformatf("word%0d_data", e), data_out, exp_data[e]);
            chk($sformatf("word%0d_valid", e), 32'(valid_out), 32'(exp_valid[e]));
            chk($sformatf("word%0d_done", e), 32'(done), 32'(exp_done[e]));
            chk($sformatf("word%0d_busy", e), 32'(busy), 32'(!exp_done[e]));
            obs_data.push_back(data_out);
            prev_data = data_out; prev_valid = valid_out; prev_busy = busy;
        end
        start = 1'b0;
        tick();
        chk("after_done_pulse", 32'(done), 32'd0);
        chk("after_done_busy", 32'(busy), 32'd0);
        chk("after_done_data", data_out, 32'd0);
    endtask

    initial begin
        int first5;
        rst = 1'b1; start = 1'b0; mode = 2'd0; rate_sel = 3'd0;
        burst_len = 16'd0; lane_mask = 4'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reset_ce", 32'(ce), 32'h1);
            chk("reset_data", data_out, 32'd0);
            chk("reset_valid", 32'(valid_out), 32'd0);
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        first5 = -1;
        for (int k = 0; k < 64; k++) begin
            tick();
            chk("div_ce", 32'(ce), 32'(ce_model(tb_div)));
            if (ce[5] && first5 < 0) first5 = tb_div;
        end
        chk("ce5_first_cycle", 32'(first5), 32'd31);
        prev_data = 32'd0; prev_valid = 4'd0; prev_busy = 1'b0;

        run_burst(0, 2, 3, 4'hF, 1'b0, -1);
        run_burst(2, 0, 2, 4'hF, 1'b0, -1);
        chk("prbs_lane0_word0", 32'(obs_data[SYNC_LEN][7:0]), 32'hE1);
        chk("prbs_lane1_word0", 32'(obs_data[SYNC_LEN][15:8]), 32'hC3);
        run_burst(3, 1, 9, 4'b0101, 1'b0, -1);
        run_burst(1, 3, 2, 4'b1010, 1'b1, -1);
        run_burst(0, 2, 0, 4'hF, 1'b0, -1);
        run_burst(0, 7, 2, 4'hF, 1'b0, -1);
        run_burst(2, 0, 3, 4'h0, 1'b0, -1);
        run_burst(2, 0, 5, 4'hF, 1'b0, SYNC_LEN + 1);
        run_burst(2, 0, 2, 4'hF, 1'b0, -1);
        for (int n = 0; n < 6; n++) begin
            run_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 6)), 4'($urandom), n[0], -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phy_lane_stimgen.md
# phy_lane_stimgen

Synthesizable, parametrised lane stimulus generator for the PCIe physical-layer bench and for on-chip loopback self-test. It replaces divided clocks with single-clock enable strobes at every power-of-two rate below `clk32f`, and drives LANES x WIDTH byte lanes with a comma preamble followed by a programmable burst (incrementing, constant, PRBS or walking-one). It sits ahead of the phy striping and serialising path, and its outputs feed the lane inputs and valid mask directly.

## Interface
- LANES, 4, number of lanes (1..8)
- WIDTH, 8, bits per lane word (8..16)
- DIV_LOG2, 5, number of divided rates; strobe k occurs every 2^k cycles
- SYNC_LEN, 4, comma words emitted before each burst (>=1)
- COMMA, 8'hBC, preamble symbol, zero-extended to WIDTH
- SEED, 16'hACE1, PRBS reset and start seed; must be non-zero

- clk32f  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  2  0 incrementing, 1 constant SEED[WIDTH-1:0], 2 PRBS, 3 walking-one
- rate_sel  in  3  selects strobe ce[rate_sel]; values > DIV_LOG2 clamp to DIV_LOG2
- burst_len  in  16  data words after preamble
- lane_mask  in  LANES  lanes to mark valid
- ce  out  DIV_LOG2+1  rate strobes; ce[0] constant 1
- data_out  out  LANES*WIDTH  lane l in bits [l*WIDTH +: WIDTH]
- valid_out  out  LANES  per-lane valid
- busy  out  1  high in SYNC, DATA and DONE
- done  out  1  one-cycle completion pulse

## Operation
- Divider: free-running DIV_LOG2-bit up-counter `div_cnt`, cleared by reset. ce[k] (k>=1) = (div_cnt[k-1:0] == all-ones), combinational from the counter. ce[k] has period 2^k, and its duty is 1 cycle.
- Latch on accepted start: mode, clamped rate_sel, burst_len and lane_mask are registered. Input changes during busy are ignored. `stb` = ce[latched rate].
- FSM: IDLE -> SYNC on start. SYNC -> DATA after SYNC_LEN strobes, or -> DONE if burst_len==0. DATA -> DONE after burst_len strobes. DONE -> IDLE on the next strobe. A start in any non-IDLE state is dropped.
- Outputs are registered and update only on edges where stb=1. Between strobes they hold.
- SYNC word: every lane = COMMA, valid_out = lane_mask.
- DATA word i (i = 0..burst_len-1), lane l, all values truncated to WIDTH:
  - mode 0: i*LANES + l, modulo 2^WIDTH.
  - mode 1: SEED[WIDTH-1:0].
  - mode 2: rotate-left(lfsr, l)[WIDTH-1:0].
  - mode 3: 1 << ((i + l) mod WIDTH).
  - valid_out = lane_mask.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shift left with feedback into bit 0. It is loaded with SEED on reset and on start, and advances once per DATA strobe after that word is formed. The first PRBS word therefore uses SEED.
- DONE strobe: data_out = 0, valid_out = 0, done = 1 for that single clock, then IDLE.
- IDLE: data_out = 0, valid_out = 0.
- i is a 16-bit counter and does not wrap within a legal burst. burst_len = 65535 is legal.

## Timing
- Reset values: div_cnt 0, ce[0]=1 and ce[k>=1]=0, data_out 0, valid_out 0, busy 0, done 0, FSM IDLE, LFSR SEED.
- start at edge t (IDLE) puts busy high from t+1. The first comma appears at the first strobe edge after t.
- Latency from start to first data word is SYNC_LEN strobes. The total burst occupies SYNC_LEN + burst_len + 1 strobes, including DONE.
- done goes high in the cycle after the DONE strobe edge, and busy falls in that same edge.
- Reset mid-operation: the next edge returns everything to reset values. The partial burst is abandoned with no done pulse.
- start coincident with reset is ignored.
- rate_sel = 0 gives back-to-back words every clock.
- lane_mask = 0 means the full sequence runs with valid_out held at 0.

## Test plan
- Reset and divider: hold reset for 3 cycles, then run 64 cycles. Check that ce[1..5] pulse at periods 2, 4, 8, 16, 32, all outputs are 0 during reset, and ce[5] first fires at cycle 31 after release.
- Incrementing burst: LANES=4, rate_sel=2, mode 0, burst_len=3, mask 4'hF.
  - Expect 4 comma words of BC on all lanes, each 4 cycles apart.
  - Then lanes {00,01,02,03}, {04,05,06,07}, {08,09,0A,0B}.
  - Then a zero word, done for one cycle, busy low.
- PRBS: mode 2, rate_sel=0, burst_len=2. Expect lane0 word0 = 8'hE1 and lane1 word0 = 8'hC3 (SEED rotated by 1). Expect word1 to use the LFSR advanced by one step.
- Walking-one with partial mask: mode 3, mask 4'b0101, burst_len=9. Check lane0 values 01,02,…,80,01, lane1 offset by one position, and valid_out = 0101 on every word.
- Edge cases:
  - burst_len=0: comma words then DONE, with no data words.
  - A start pulse while busy is dropped.
  - rate_sel=7 behaves identically to 5.
- Reset at the second data word: outputs are zero on the next edge, no done pulse, and a fresh start restarts from commas with the LFSR at SEED.
